alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 20 ++
 rtl/alu_arbiter_alu.sv | 27 ++
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types, ALU opcode codes and FSM state encoding for the two-requester ALU arbiter.
package alu_arbiter_pkg;

  typedef logic [31:0] u32;
  typedef logic [2:0]  u3;
  typedef logic        u1;

  localparam u3 ALU_AND = 3'b000;
  localparam u3 ALU_OR  = 3'b001;
  localparam u3 ALU_ADD = 3'b010;
  localparam u3 ALU_SUB = 3'b110;
  localparam u3 ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU; unknown opcodes yield result 0 with the error flag set.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  u32 a,
  input  u32 b,
  input  u3  op,
  output u32 result,
  output u1  zero,
  output u1  err
);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: err = 1'b1;
    endcase
    zero = (result == 32'd0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end to one shared ALU: arbitrate, execute, then hold the
// response until the granted requester consumes it. One operation in flight.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int PRIO_FIXED = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [2:0]       req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [31:0]      resp0_result,
  output logic             resp0_zero,
  output logic             resp0_err,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [31:0]      resp1_result,
  output logic             resp1_zero,
  output logic             resp1_err,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  state_e     state_q, state_d;
  u1          gnt_q, last_q, pick;
  u32         a_q, b_q, res_q, alu_res;
  u3          op_q;
  u1          zero_q, err_q, alu_zero, alu_err;
  logic [CNT_W-1:0] ops_q;
  logic       accept, resp_hs;

  // Tie-break: fixed mode favours 0, round-robin favours whoever did not finish last.
  always_comb begin
    if (req0_valid && req1_valid) pick = (PRIO_FIXED != 0) ? 1'b0 : ~last_q;
    else                          pick = req1_valid;
  end

  assign accept  = (state_q == IDLE) && (req0_valid || req1_valid);
  assign resp_hs = (state_q == RESP) && (gnt_q ? resp1_ready : resp0_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)  state_d = EXEC;
      EXEC:                 state_d = RESP;
      RESP:    if (resp_hs) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready   = accept && !pick;
    req1_ready   = accept &&  pick;
    resp0_valid  = (state_q == RESP) && !gnt_q;
    resp1_valid  = (state_q == RESP) &&  gnt_q;
    resp0_result = resp0_valid ? res_q  : 32'd0;
    resp0_zero   = resp0_valid ? zero_q : 1'b0;
    resp0_err    = resp0_valid ? err_q  : 1'b0;
    resp1_result = resp1_valid ? res_q  : 32'd0;
    resp1_zero   = resp1_valid ? zero_q : 1'b0;
    resp1_err    = resp1_valid ? err_q  : 1'b0;
    busy         = (state_q != IDLE);
  end

  alu_arbiter_alu u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_res),
    .zero   (alu_zero),
    .err    (alu_err)
  );

  // Operand/result registers are cleared by reset so an aborted operation leaves no trace.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q  <= 1'b0;
      last_q <= 1'b1;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
      ops_q  <= '0;
    end else begin
      if (accept) begin
        gnt_q <= pick;
        a_q   <= pick ? req1_a  : req0_a;
        b_q   <= pick ? req1_b  : req0_b;
        op_q  <= pick ? req1_op : req0_op;
      end
      if (state_q == EXEC) begin
        res_q  <= alu_res;
        zero_q <= alu_zero;
        err_q  <= alu_err;
      end
      if (resp_hs) begin
        last_q <= gnt_q;
        ops_q  <= ops_q + CNT_W'(1);
      end
    end
  end

  assign ops_done = ops_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: a round-robin/16-bit-counter instance and a fixed-priority/2-bit-counter
// instance share all inputs; expected values are hand-computed per vector.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0_valid, req1_valid, resp0_ready, resp1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;

  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [31:0] resp0_result, resp1_result;
  logic        resp0_zero, resp1_zero, resp0_err, resp1_err, busy;
  logic [15:0] ops_done;

  logic        fx_req0_ready, fx_req1_ready, fx_resp0_valid, fx_resp1_valid;
  logic [31:0] fx_resp0_result, fx_resp1_result;
  logic        fx_resp0_zero, fx_resp1_zero, fx_resp0_err, fx_resp1_err, fx_busy;
  logic [1:0]  fx_ops_done;

  int n_tests = 0;
  int n_fail  = 0;

  alu_arbiter #(.PRIO_FIXED(0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
    .resp0_zero(resp0_zero), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
    .resp1_zero(resp1_zero), .resp1_err(resp1_err),
    .busy(busy), .ops_done(ops_done)
  );

  alu_arbiter #(.PRIO_FIXED(1), .CNT_W(2)) dut_fx (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(fx_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(fx_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(fx_resp0_valid), .resp0_ready(resp0_ready), .resp0_result(fx_resp0_result),
    .resp0_zero(fx_resp0_zero), .resp0_err(fx_resp0_err),
    .resp1_valid(fx_resp1_valid), .resp1_ready(resp1_ready), .resp1_result(fx_resp1_result),
    .resp1_zero(fx_resp1_zero), .resp1_err(fx_resp1_err),
    .busy(fx_busy), .ops_done(fx_ops_done)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One isolated operation on requester r, checking accept, latency and response.
  task automatic single_op(input bit r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           input logic [31:0] er, input logic ez, input logic ee, input string tag);
    @(negedge clk);
    if (!r) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    else    begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    #1;
    check_eq({tag, "_rdy"}, r ? req1_ready : req0_ready, 1);
    check_eq({tag, "_rdy_other"}, r ? req0_ready : req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq({tag, "_exec_busy"}, busy, 1);
    check_eq({tag, "_exec_vld"}, r ? resp1_valid : resp0_valid, 0);
    @(negedge clk);
    check_eq({tag, "_vld"}, r ? resp1_valid : resp0_valid, 1);
    check_eq({tag, "_res"}, r ? resp1_result : resp0_result, er);
    check_eq({tag, "_zero"}, r ? resp1_zero : resp0_zero, ez);
    check_eq({tag, "_err"}, r ? resp1_err : resp0_err, ee);
    if (!r) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    check_eq({tag, "_done_vld"}, r ? resp1_valid : resp0_valid, 0);
    check_eq({tag, "_done_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b0; resp1_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;

    // Reset state
    #3;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rdy0", req0_ready, 0);
    check_eq("rst_vld0", resp0_valid, 0);
    check_eq("rst_res0", resp0_result, 0);
    check_eq("rst_ops", ops_done, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Both valid straight out of reset: requester 0 first, then 1
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd10000; req0_b = 32'd32; req0_op = ALU_ADD;
    req1_valid = 1'b1; req1_a = 32'd100;   req1_b = 32'd50; req1_op = ALU_SUB;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    #1;
    check_eq("tie_rdy0", req0_ready, 1);
    check_eq("tie_rdy1", req1_ready, 0);
    check_eq("tie_fx_rdy0", fx_req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    check_eq("tie_exec_rdy1", req1_ready, 0);
    @(negedge clk);
    check_eq("tie_vld0", resp0_valid, 1);
    check_eq("tie_res0", resp0_result, 10032);
    check_eq("tie_vld1_idle", resp1_valid, 0);
    @(negedge clk);
    check_eq("tie_ops1", ops_done, 1);
    check_eq("tie_rdy1b", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    check_eq("tie_vld1", resp1_valid, 1);
    check_eq("tie_res1", resp1_result, 50);
    check_eq("tie_vld0_idle", resp0_valid, 0);
    check_eq("tie_res0_idle", resp0_result, 0);
    @(negedge clk);
    check_eq("tie_ops2", ops_done, 2);
    check_eq("tie_fx_ops2", fx_ops_done, 2);

    // Continuous contention: round-robin alternates, fixed priority always picks 0
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = ALU_ADD;
    req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd1; req1_op = ALU_OR;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("rr%0d_rdy0", i), req0_ready, (i % 2 == 0) ? 1 : 0);
      check_eq($sformatf("rr%0d_rdy1", i), req1_ready, (i % 2 == 1) ? 1 : 0);
      check_eq($sformatf("fx%0d_rdy0", i), fx_req0_ready, 1);
      check_eq($sformatf("fx%0d_rdy1", i), fx_req1_ready, 0);
      @(negedge clk);
      @(negedge clk);
      check_eq($sformatf("rr%0d_res", i), (i % 2 == 1) ? resp1_result : resp0_result,
               (i % 2 == 1) ? 5 : 2);
      check_eq($sformatf("fx%0d_vld0", i), fx_resp0_valid, 1);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b0; resp1_ready = 1'b0;
    check_eq("rr_ops6", ops_done, 6);
    check_eq("fx_ops_wrap", fx_ops_done, 2);

    // Single operations, including SLT both ways and an illegal opcode
    single_op(1'b0, 32'd150, 32'd50, ALU_AND, 32'd18, 1'b0, 1'b0, "and");
    single_op(1'b0, 32'd10, 32'd11, ALU_SLT, 32'd1, 1'b0, 1'b0, "slt_lt");
    single_op(1'b0, 32'd10, 32'd5,  ALU_SLT, 32'd0, 1'b1, 1'b0, "slt_ge");
    single_op(1'b0, 32'd7,  32'd9,  3'd3,    32'd0, 1'b1, 1'b1, "illegal");
    check_eq("ops10", ops_done, 10);

    // Response back-pressure, then reset while an operation executes
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd5; req0_op = ALU_ADD;
    #1;
    check_eq("stall_rdy0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd1; req1_op = ALU_SUB;
    @(negedge clk);
    check_eq("stall_vld0", resp0_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("stall%0d_vld0", i), resp0_valid, 1);
      check_eq($sformatf("stall%0d_res0", i), resp0_result, 10);
      check_eq($sformatf("stall%0d_busy", i), busy, 1);
      check_eq($sformatf("stall%0d_rdy1", i), req1_ready, 0);
    end
    resp0_ready = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b0;
    check_eq("stall_ops11", ops_done, 11);
    check_eq("stall_rdy1_idle", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    check_eq("exec_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_ops", ops_done, 0);
    check_eq("arst_vld1", resp1_valid, 0);
    check_eq("arst_rdy1", req1_ready, 0);
    resp1_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("post_rst%0d_vld1", i), resp1_valid, 0);
      check_eq($sformatf("post_rst%0d_busy", i), busy, 0);
    end
    resp1_ready = 1'b0;

    // Narrow counter wraps 1,2,3,0,1
    for (int i = 0; i < 5; i++) begin
      single_op(1'b0, 32'(i + 1), 32'd0, ALU_OR, 32'(i + 1), 1'b0, 1'b0, $sformatf("cnt%0d", i));
      check_eq($sformatf("cnt%0d_fx_ops", i), fx_ops_done, (i + 1) % 4);
      check_eq($sformatf("cnt%0d_ops", i), ops_done, i + 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
